// File: rtl/mont_mul_pipe_pkg.sv
// Shared constants for the Montgomery multiplier pipeline.
// Default operand width, multiplier register depth and tag width used as
// parameter defaults by mont_mul_pipe and its multiplier sub-module.
package mont_mul_pipe_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefMulLat    = 2;
  localparam int unsigned DefTagWidth  = 4;

endpackage

// File: rtl/mont_mul_pipe_mul.sv
// Unsigned DW x DW -> 2*DW multiplier with MUL_LAT enabled register stages.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           advance enable; all stages hold when low
//   a_i, b_i       operands
//   prod_o         product, MUL_LAT advancing cycles after the operands
module mont_mul_pipe_mul
  import mont_mul_pipe_pkg::*;
#(
  parameter int unsigned DW      = DefDataWidth,
  parameter int unsigned MUL_LAT = DefMulLat
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic [2*DW-1:0] prod_o
);

  logic [2*DW-1:0] prod_q [MUL_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else if (en_i) begin
      prod_q[0] <= {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
      for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign prod_o = prod_q[MUL_LAT-1];

endmodule

// File: rtl/mont_mul_pipe.sv
// Fully pipelined Montgomery multiplier: out = a*b*R^-1 mod p, R = 2^DW,
// fully reduced into [0, p). Modulus, constant mu and tag travel with each op.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     input handshake (in_ready_o is combinational)
//   in_a_i, in_b_i, in_p_i      operands (< p) and odd modulus (< 2^(DW-1))
//   in_mu_i                     -p^-1 mod 2^DW
//   in_tag_i                    opaque tag returned with the result
//   out_valid_o / out_ready_i   output handshake
//   out_data_o, out_tag_o       result and its tag
module mont_mul_pipe
  import mont_mul_pipe_pkg::*;
#(
  parameter int unsigned DW      = DefDataWidth,
  parameter int unsigned MUL_LAT = DefMulLat,
  parameter int unsigned TAG_W   = DefTagWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_a_i,
  input  logic [DW-1:0]    in_b_i,
  input  logic [DW-1:0]    in_p_i,
  input  logic [DW-1:0]    in_mu_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic [TAG_W-1:0] out_tag_o
);

  // Side-band carried alongside the a*b multiplier.
  typedef struct packed {
    logic             v;
    logic [DW-1:0]    p;
    logic [DW-1:0]    mu;
    logic [TAG_W-1:0] tag;
  } sb_a_t;

  // Side-band carried alongside the m and m*p multipliers.
  typedef struct packed {
    logic             v;
    logic [DW-1:0]    p;
    logic [DW-1:0]    th;
    logic             c;
    logic [TAG_W-1:0] tag;
  } sb_bc_t;

  logic adv;
  logic out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  sb_a_t  sb_a_q [MUL_LAT];
  sb_bc_t sb_b_q [MUL_LAT];
  sb_bc_t sb_c_q [MUL_LAT];
  sb_a_t  sb_a_d, a_out;
  sb_bc_t sb_b_d, b_out, c_out;

  logic [2*DW-1:0] prod_t, prod_m, prod_mp;
  logic [DW:0] u, red;

  // One global advance: the whole pipe moves unless a result is being held.
  assign adv        = ~out_valid_q | out_ready_i;
  assign in_ready_o = adv;

  assign a_out = sb_a_q[MUL_LAT-1];
  assign b_out = sb_b_q[MUL_LAT-1];
  assign c_out = sb_c_q[MUL_LAT-1];

  mont_mul_pipe_mul #(.DW(DW), .MUL_LAT(MUL_LAT)) u_mul_t (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (adv),
    .a_i    (in_a_i),
    .b_i    (in_b_i),
    .prod_o (prod_t)
  );

  mont_mul_pipe_mul #(.DW(DW), .MUL_LAT(MUL_LAT)) u_mul_m (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (adv),
    .a_i    (prod_t[DW-1:0]),
    .b_i    (a_out.mu),
    .prod_o (prod_m)
  );

  mont_mul_pipe_mul #(.DW(DW), .MUL_LAT(MUL_LAT)) u_mul_mp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (adv),
    .a_i    (prod_m[DW-1:0]),
    .b_i    (b_out.p),
    .prod_o (prod_mp)
  );

  always_comb begin
    sb_a_d     = '0;
    sb_a_d.v   = in_valid_i & adv;
    sb_a_d.p   = in_p_i;
    sb_a_d.mu  = in_mu_i;
    sb_a_d.tag = in_tag_i;

    sb_b_d     = '0;
    sb_b_d.v   = a_out.v;
    sb_b_d.p   = a_out.p;
    sb_b_d.th  = prod_t[2*DW-1:DW];
    // T_L + (m*p)_L is 0 mod R, so the low half carries exactly when T_L != 0.
    sb_b_d.c   = |prod_t[DW-1:0];
    sb_b_d.tag = a_out.tag;

    u   = {1'b0, c_out.th} + {1'b0, prod_mp[2*DW-1:DW]} + {{DW{1'b0}}, c_out.c};
    red = (u >= {1'b0, c_out.p}) ? (u - {1'b0, c_out.p}) : u;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        sb_a_q[i] <= '0;
        sb_b_q[i] <= '0;
        sb_c_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      sb_a_q[0] <= sb_a_d;
      sb_b_q[0] <= sb_b_d;
      sb_c_q[0] <= b_out;
      for (int i = 1; i < MUL_LAT; i++) begin
        sb_a_q[i] <= sb_a_q[i-1];
        sb_b_q[i] <= sb_b_q[i-1];
        sb_c_q[i] <= sb_c_q[i-1];
      end
      out_valid_q <= c_out.v;
      out_data_q  <= red[DW-1:0];
      out_tag_q   <= c_out.tag;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_tag_o   = out_tag_q;

  // Product halves not needed by the reduction; u < 2p < 2^DW keeps red[DW] clear.
  logic unused_bits;
  assign unused_bits = ^{prod_m[2*DW-1:DW], prod_mp[DW-1:0], red[DW]};

endmodule

// File: tb/tb_mont_mul_pipe.sv
module tb_mont_mul_pipe;
  localparam int unsigned DW      = 16;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned LAT     = 3 * MUL_LAT + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_a = '0, in_b = '0, in_p = '0, in_mu = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mont_mul_pipe #(.DW(DW), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_p_i      (in_p),
    .in_mu_i     (in_mu),
    .in_tag_i    (in_tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_tag_o   (out_tag)
  );

  typedef struct {
    int unsigned data;
    int unsigned tag;
    longint      stamp;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   new_e;
  longint adv_cnt = 0;
  bit     rand_ready = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // a*b*2^-DW mod p by repeated exact halving modulo the odd p.
  function automatic int unsigned model(input int unsigned a, input int unsigned b,
                                        input int unsigned p);
    longint unsigned t;
    t = longint'(a) * longint'(b);
    for (int i = 0; i < DW; i++) begin
      if (t[0]) t = t + p;
      t = t >> 1;
    end
    return int'(t % p);
  endfunction

  // -p^-1 mod 2^DW via Newton iteration.
  function automatic int unsigned mu_of(input int unsigned p);
    longint unsigned inv;
    inv = p;
    for (int i = 0; i < 5; i++) inv = (inv * (2 - p * inv)) & 64'hFFFF;
    return int'((64'h10000 - inv) & 64'hFFFF);
  endfunction

  // Scoreboard: outputs are stable mid-cycle, acceptance happens at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_tag", out_tag, 0);
      check("reset in_ready", in_ready, 1);
    end else begin
      check("in_ready rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious out_valid", out_valid, 0);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_tag", out_tag, exp_q[0].tag);
          check("latency", adv_cnt - exp_q[0].stamp, LAT);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        new_e.data  = model(in_a, in_b, in_p);
        new_e.tag   = in_tag;
        new_e.stamp = adv_cnt;
        exp_q.push_back(new_e);
      end
      if (in_ready) adv_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents an op and returns just after the edge that accepted it; in_valid stays high.
  task automatic send(input int unsigned a, input int unsigned b, input int unsigned p,
                      input int unsigned mu, input int unsigned tag);
    bit ok;
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_p     = 16'(p);
    in_mu    = 16'(mu);
    in_tag   = 4'(tag);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) fail("accept timeout");
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step(1);
      n++;
    end
    if (!out_valid) fail("wait out_valid");
  endtask

  initial begin
    int unsigned p, a, b;

    // Pin the model against hand-computed values.
    check("model 1*1 mod 12289", model(1, 1, 12289), 2304);
    check("model 4091*5 mod 12289", model(4091, 5, 12289), 5);
    check("model 0*777 mod 12289", model(0, 777, 12289), 0);
    check("model 12288^2 mod 12289", model(12288, 12288, 12289), 2304);
    check("model 1*1 mod 17", model(1, 1, 17), 1);
    check("mu 12289", mu_of(12289), 12287);
    check("mu 17", mu_of(17), 3855);

    // Reset, then 20 idle cycles.
    step(3);
    check("in reset out_valid", out_valid, 0);
    check("in reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle in_ready", in_ready, 1);
      check("idle out_valid", out_valid, 0);
      check("idle out_data", out_data, 0);
    end

    // Single op: result exactly LAT edges after acceptance.
    send(1, 1, 12289, 12287, 3);
    in_valid = 1'b0;
    for (int k = 1; k <= int'(LAT); k++) begin
      if (k > 1) step(1);
      check("single op out_valid timing", out_valid, (k == int'(LAT)) ? 1 : 0);
    end
    check("single op out_data", out_data, 2304);
    check("single op out_tag", out_tag, 3);
    step(3);

    // Back-to-back, including a zero operand and the p-1 corner.
    send(4091, 5, 12289, 12287, 0);
    send(0, 777, 12289, 12287, 1);
    send(12288, 12288, 12289, 12287, 2);
    // Modulus switch on consecutive ops.
    send(1, 1, 12289, 12287, 5);
    send(1, 1, 17, 3855, 6);
    in_valid = 1'b0;
    step(12);

    // Hold the output for 5 cycles while a new op is offered.
    send(7, 9, 12289, 12287, 1);
    send(100, 200, 12289, 12287, 2);
    send(12000, 11000, 12289, 12287, 3);
    in_valid = 1'b0;
    wait_out_valid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 16'd5; in_b = 16'd6; in_p = 16'd12289; in_mu = 16'd12287; in_tag = 4'd4;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("stall out_valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(5, 6, 12289, 12287, 4);
    in_valid = 1'b0;
    step(15);
    check("queue empty after stall", exp_q.size(), 0);

    // Reset with the pipe full and a result held.
    out_ready = 1'b0;
    for (int i = 0; i < int'(LAT); i++) send(i + 2, 3, 12289, 12287, i + 8);
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_data", out_data, 0);
    check("async reset out_tag", out_tag, 0);
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(20);

    // Randomized traffic with random back-pressure and random moduli.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      p = $urandom_range(1, 16383) * 2 + 1;
      a = $urandom_range(0, p - 1);
      b = $urandom_range(0, p - 1);
      send(a, b, p, mu_of(p), $urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3) begin
        in_valid = 1'b0;
        step($urandom_range(1, 3));
      end
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step(1);
    check("queue drained", exp_q.size(), 0);
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_mul_pipe.md
# mont_mul_pipe

Parametrised, fully pipelined Montgomery modular multiplier for the NTT butterfly datapath. It computes a·b·R⁻¹ mod p with R = 2^DW and accepts one operation per cycle. It adds three things to the existing fixed-width multiplier: a valid/ready handshake with global back-pressure, a modulus and constant carried with each operation (so p may change every cycle), and a final conditional subtraction that returns a fully reduced result in [0, p). It sits between the twiddle ROM / operand muxes and the butterfly adder/subtractor.

## Interface
- DW, default `datawidth (16): operand and modulus width; R = 2^DW.
- MUL_LAT, default 2: register stages inside each of the three multipliers (legal 1..3).
- TAG_W, default 4: width of the user tag carried alongside each operation.

- clk  in  1  clock; all state changes on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  an operation is offered.
- in_ready  out  1  the block accepts the offered operation this cycle.
- in_a, in_b  in  DW  operands; each must be < in_p.
- in_p  in  DW  odd modulus; must be < 2^(DW-1).
- in_mu  in  DW  −p⁻¹ mod 2^DW for this in_p.
- in_tag  in  TAG_W  opaque tag; returned unchanged with the result.
- out_valid  out  1  out_data and out_tag hold a result.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  DW  a·b·R⁻¹ mod p, in [0, p).
- out_tag  out  TAG_W  tag of the result.

## Operation
- Stage A: T = a·b (2DW bits). T_L = T[DW-1:0], T_H = T[2DW-1:DW].
- Stage B: m = (T_L·mu) mod R.
- Stage C: Q_H = (m·p)[2DW-1:DW].
- carry = (T_L != 0). This holds because T_L + (m·p)_L ≡ 0 mod R.
- Final stage: U = T_H + Q_H + carry, computed on DW+1 bits. U < 2p. out = (U ≥ p) ? U − p : U, registered.
- T_H, carry, p, mu and tag travel with each operation as per-stage pipeline registers. Each stage also holds its own valid bit. Nothing is delayed by a free-running chain that is separate from the valid bits.
- Global stall: adv = !out_valid | out_ready. When adv = 0, every pipeline register, including the multiplier internals, holds its value.
- in_ready = adv. An operation is accepted when in_valid & in_ready. An accepted operation enters stage A with valid = 1. If nothing is accepted, a bubble (valid = 0) enters instead.
- Bubbles do not collapse while stalled. Pipeline occupancy is fixed at LAT slots.
- Operations leave in acceptance order, with no drops and no duplicates.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_tag = 0. All stage valid bits = 0. Data registers = 0.
- Latency: LAT = 3·MUL_LAT + 1 advancing cycles from the acceptance edge to out_valid = 1. This is 7 cycles for the default MUL_LAT.
- Throughput: 1 operation per cycle while out_ready = 1.
- out_valid & !out_ready: out_data and out_tag stay stable until the handshake completes. in_ready = 0 during this time.
- in_ready is combinational from out_ready. The bench must not treat this as a register.
- Simultaneous out handshake and in acceptance in the same cycle is legal; both happen.
- rstn asserted mid-operation: all in-flight operations are discarded immediately, outputs take their reset values, and nothing is replayed after release.
- Operands ≥ p, or an even p: the output is undefined, but the handshake and ordering are still preserved.

## Structure
- The shared header ntt_define.vh gains the default constants `datawidth, `mul_lat and `tag_w. No new types are needed.
- One sub-module: mul_pipe. It is a DW×DW → 2DW unsigned multiplier with MUL_LAT registers and an enable input, instantiated three times. All three instances are driven by adv.
- The existing DFF cell is not used for stage registers, because those registers need an enable.

## Test plan
DW=16, MUL_LAT=2, p=12289, mu=12287, R mod p=4091.
- Reset release with in_valid=0 → in_ready=1, out_valid=0, out_data=0 for 20 cycles.
- a=1, b=1, tag=3 → exactly 7 cycles later: out_valid=1, out_data=2304, out_tag=3.
- Back-to-back with out_ready=1: (4091,5), (0,777), (12288,12288) → 5, 0, 2304 on consecutive cycles.
- Modulus switch: p=12289 (a=b=1) immediately followed by p=17, mu=3855 (a=b=1) → 2304, then 1.
- Hold out_ready=0 for 5 cycles while a result is valid → out_data and out_tag are frozen, in_ready=0, no input is accepted. Release → all queued results arrive in order with no loss.
- Pulse rstn low while 4 operations are in flight → out_valid=0 and out_data=0 at once. After release, no stale results appear.
